// File: rtl/qpg_pkg.sv
// Shared types and constants for the quadrature pulse generator.
package qpg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } qpg_state_e;

    // {A,B} per phase, packed with phase 0 in the low bits: 00,10,11,01
    localparam logic [7:0] PHASE_AB_LUT = 8'b01_11_10_00;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    localparam int unsigned MIN_PERIOD_DEF = 2;

    function automatic logic [1:0] phase_ab(input logic [1:0] phase);
        return PHASE_AB_LUT[{phase, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running divider producing a one-clk pulse every CLK_DIV clocks (1 us timebase).
module us_tick_gen #(
    parameter int unsigned CLK_DIV = 80
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/quad_pulse_gen.sv
// Quadrature A/B/Z generator driven by a signed line count and per-edge period in us.
// Define QPG_ZPULSE_EN to build the line index tracker and the Z index output.
module quad_pulse_gen
    import qpg_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 80,
    parameter int unsigned LINES      = 200,
    parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_steps,
    input  logic [15:0] cmd_period,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        a_o,
    output logic        b_o,
    output logic        z_o,
    output logic [15:0] pos_o
);

    localparam logic [15:0] MIN_P = 16'(MIN_PERIOD);

    if (LINES < 2 || LINES > 65535) begin : g_bad_lines
        $error("quad_pulse_gen: LINES out of range 2..65535");
    end

    logic tick;

    us_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    qpg_state_e  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] period_q, period_d;
    logic [16:0] remaining_q, remaining_d;
    logic        dir_q, dir_d;
    logic [1:0]  phase_q, phase_d;
    logic [15:0] pos_q, pos_d;
    logic        a_q, a_d, b_q, b_d;
    logic        cmd_ready_q, busy_q, done_q;
    logic        cnt_up_c, cnt_dn_c;
    logic [16:0] steps_ext;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        period_d    = period_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        phase_d     = phase_q;
        pos_d       = pos_q;
        cnt_up_c    = 1'b0;
        cnt_dn_c    = 1'b0;
        steps_ext   = {cmd_steps[15], cmd_steps};

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // 17-bit magnitude so that -32768 becomes 32768 without overflow
                    dir_d       = cmd_steps[15] ? DIR_CCW : DIR_CW;
                    remaining_d = cmd_steps[15] ? 17'(-steps_ext) : steps_ext;
                    period_d    = (cmd_period < MIN_P) ? MIN_P : cmd_period;
                    timer_d     = '0;
                    state_d     = (cmd_steps == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    if (timer_q == period_q - 16'd1) begin
                        timer_d = '0;
                        if (dir_q == DIR_CW) begin
                            phase_d  = phase_q + 2'd1;
                            cnt_up_c = (phase_q == 2'd1);
                        end else begin
                            phase_d  = phase_q - 2'd1;
                            cnt_dn_c = (phase_q == 2'd3);
                        end
                        if (cnt_up_c) pos_d = pos_q + 16'd1;
                        if (cnt_dn_c) pos_d = pos_q - 16'd1;
                        // Returning to phase 0 closes a line; abort only honoured here
                        if (phase_d == 2'd0) begin
                            remaining_d = remaining_q - 17'd1;
                            if (remaining_d == 17'd0 || abort) state_d = DONE;
                        end
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        {a_d, b_d} = phase_ab(phase_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            period_q    <= MIN_P;
            remaining_q <= '0;
            dir_q       <= DIR_CW;
            phase_q     <= 2'd0;
            pos_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            period_q    <= period_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            phase_q     <= phase_d;
            pos_q       <= pos_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cmd_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

`ifdef QPG_ZPULSE_EN
    localparam logic [15:0] LINE_LAST = 16'(LINES - 1);

    logic [15:0] line_idx_q, line_idx_d;
    logic        z_q, z_d;

    // Line index moves on the same counting edge as pos, so Z rises with that edge
    always_comb begin
        line_idx_d = line_idx_q;
        if (cnt_up_c) line_idx_d = (line_idx_q == LINE_LAST) ? 16'd0 : line_idx_q + 16'd1;
        if (cnt_dn_c) line_idx_d = (line_idx_q == 16'd0) ? LINE_LAST : line_idx_q - 16'd1;
        z_d = (line_idx_d == 16'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_idx_q <= LINE_LAST;
            z_q        <= 1'b0;
        end else begin
            line_idx_q <= line_idx_d;
            z_q        <= z_d;
        end
    end

    assign z_o = z_q;
`else
    assign z_o = 1'b0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign a_o       = a_q;
    assign b_o       = b_q;
    assign pos_o     = pos_q;

endmodule
